dma_chan_reg_file: RTL and testbench
====================================

DMA_CHAN_REG_FILE -- requirements
Module: dma_chan_reg_file

Interface
REQ-001 Parameter NUM_CH, default 4, meaning channel count, legal 1..8.
REQ-002 Parameter DATA_W, default 32, meaning host data and address-register width.
REQ-003 Parameter ADDR_W, default 24, meaning host address width.
REQ-004 Parameter BASE_ADDR, default 24'h080000, meaning register window base; channel n occupies BASE_ADDR+8n .. +8n+7.
REQ-005 Parameter LEN_W, default 16, meaning byte-length counter width.
REQ-006 clk0  in  1  clock, all state on rising edge.
REQ-007 reset  in  1  asynchronous, active-high.
REQ-008 host_cmd  in  3  3'b010 write, 3'b001 read, all other codes no-op.
REQ-009 host_addr  in  ADDR_W  register address.
REQ-010 host_datain  in  DATA_W  write data.
REQ-011 host_dataout  out  DATA_W  registered read data.
REQ-012 host_rd_valid  out  1  one-cycle pulse, host_dataout valid.
REQ-013 xfer_req  out  1  a granted channel requests one beat.
REQ-014 xfer_ch  out  3  granted channel index.
REQ-015 xfer_src, xfer_dst  out  DATA_W each  current addresses of granted channel.
REQ-016 xfer_size  out  2  0 byte, 1 half-word, 2 word.
REQ-017 xfer_ack  in  1  beat completed for xfer_ch.
REQ-018 irq  out  NUM_CH  per-channel interrupt level.

Function
REQ-019 Per-channel offsets: 0 STATUS, 1 SRC, 2 DST, 3 LEN, 4 CTRL; offsets 5..7 read 0, writes ignored; addresses outside the window ignored (no rd_valid).
REQ-020 STATUS bits: [0] done, [1] busy, [2] err, [3] aborted; done/err/aborted write-1-to-clear, busy read-only.
REQ-021 CTRL bits: [1:0] size, [2] src_inc, [3] dst_inc, [4] ien, [5] go (self-clearing, reads 0), [6] abort (self-clearing, reads 0).
REQ-022 Read latency one cycle: host_dataout and host_rd_valid update on the edge after a read command; host_dataout holds otherwise.
REQ-023 Per-channel FSM states IDLE, BUSY, DONE.
REQ-024 IDLE -> BUSY on go=1 with LEN!=0 and size<=2; busy set.
REQ-025 IDLE -> DONE with err set on go=1 when LEN==0 or size==3.
REQ-026 BUSY: on xfer_ack for this channel, LEN -= step (1/2/4); SRC += step if src_inc; DST += step if dst_inc; address wrap modulo 2^DATA_W.
REQ-027 BUSY -> DONE when the acked step >= remaining LEN; LEN becomes 0 (no underflow); busy cleared, done set.
REQ-028 BUSY -> IDLE on abort=1; aborted set, busy cleared, LEN/SRC/DST keep current values; abort in the same cycle as an ack wins and the ack is discarded.
REQ-029 DONE -> IDLE when host clears done or err (W1C) and neither remains set; go in DONE is ignored.
REQ-030 Host writes to SRC, DST, LEN in BUSY are ignored; CTRL writes in BUSY update only abort.
REQ-031 irq[n] = ien & (done | err | aborted) of channel n.
REQ-032 Arbitration round-robin among BUSY channels; grant held until xfer_ack or the channel leaves BUSY; next search starts at granted index+1 mod NUM_CH.
REQ-033 xfer_req asserted whenever a grant is held; xfer_ch/src/dst/size stable while xfer_req is high; new grant no earlier than the cycle after ack.
REQ-034 xfer_ack with xfer_req low is ignored.
REQ-035 Host W1C and hardware set of the same status bit in one cycle: set wins.

Reset
REQ-036 On reset all registers, LEN, FSMs (IDLE), grant pointer (channel 0), host_dataout, host_rd_valid, xfer_req, irq go to 0, including mid-transfer; takes effect immediately.

Verification
REQ-037 Ch0 SRC=0x100, DST=0x200, LEN=8, CTRL size=2,inc both,ien,go; ack twice -> SRC=0x108, DST=0x208, LEN=0, STATUS=0x1, irq[0]=1.
REQ-038 Ch1 LEN=3, size=1, go; ack twice -> LEN 1 then 0, DONE after second ack, no underflow.
REQ-039 Ch2 LEN=0, go -> STATUS=0x5 (done+err) next cycle, xfer_req never asserted; write 0x5 to STATUS -> 0, IDLE.
REQ-040 Ch0 and ch3 busy, ack every beat -> xfer_ch alternates 0,3,0,3.
REQ-041 Ch1 busy, abort and ack same cycle -> LEN unchanged, STATUS=0x8, xfer_req drops next cycle.
REQ-042 Reset asserted mid-transfer -> all outputs 0 asynchronously; read of BASE_ADDR+8 after release returns 0 with host_rd_valid one cycle later.

Source files
------------

// File: rtl/dma_chan_reg_file_if.sv
// Host register bus and DMA beat request/acknowledge bundle for dma_chan_reg_file.
// The master side drives host commands and xfer_ack; the slave side is the register file.
interface dma_chan_reg_file_if #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 24
);
  logic [2:0]        host_cmd;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_datain;
  logic [DATA_W-1:0] host_dataout;
  logic              host_rd_valid;
  logic              xfer_req;
  logic [2:0]        xfer_ch;
  logic [DATA_W-1:0] xfer_src;
  logic [DATA_W-1:0] xfer_dst;
  logic [1:0]        xfer_size;
  logic              xfer_ack;
  logic [NUM_CH-1:0] irq;

  modport master (
    output host_cmd, host_addr, host_datain, xfer_ack,
    input  host_dataout, host_rd_valid, xfer_req, xfer_ch, xfer_src, xfer_dst, xfer_size, irq
  );

  modport slave (
    input  host_cmd, host_addr, host_datain, xfer_ack,
    output host_dataout, host_rd_valid, xfer_req, xfer_ch, xfer_src, xfer_dst, xfer_size, irq
  );
endinterface

// File: rtl/dma_chan_reg_file.sv
// DMA channel register file: per-channel SRC/DST/LEN/CTRL/STATUS registers, a per-channel
// IDLE/BUSY/DONE FSM and a round-robin arbiter issuing one beat request at a time.
module dma_chan_reg_file #(
  parameter int unsigned       NUM_CH    = 4,
  parameter int unsigned       DATA_W    = 32,
  parameter int unsigned       ADDR_W    = 24,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 24'h080000,
  parameter int unsigned       LEN_W     = 16
) (
  input logic               clk0,
  input logic               reset,
  dma_chan_reg_file_if.slave io_bus
);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  logic [DATA_W-1:0] r_src   [NUM_CH];
  logic [DATA_W-1:0] r_dst   [NUM_CH];
  logic [LEN_W-1:0]  r_len   [NUM_CH];
  logic [1:0]        r_size  [NUM_CH];
  state_e            r_state [NUM_CH];
  logic [NUM_CH-1:0] r_sinc, r_dinc, r_ien, r_done, r_err, r_abt;
  logic              r_req;
  logic [2:0]        r_gnt, r_ptr;
  logic [DATA_W-1:0] r_rdata;
  logic              r_rd_valid;

  logic [ADDR_W-1:0] w_off;
  logic              w_hit, w_wr, w_rd;
  logic [2:0]        w_ch, w_reg;
  logic [DATA_W-1:0] w_wdata;
  logic [NUM_CH-1:0] w_sel, w_busy, w_ack, w_abort;
  logic [LEN_W-1:0]  w_step [NUM_CH];
  logic              w_found, w_gabort;
  logic [2:0]        w_next;
  logic [DATA_W-1:0] w_rdata, w_xsrc, w_xdst;
  logic [1:0]        w_xsize;

  assign w_off   = io_bus.host_addr - BASE_ADDR;
  assign w_hit   = (io_bus.host_addr >= BASE_ADDR) && (w_off < ADDR_W'(8 * NUM_CH));
  assign w_ch    = w_off[5:3];
  assign w_reg   = w_off[2:0];
  assign w_wr    = w_hit && (io_bus.host_cmd == 3'b010);
  assign w_rd    = w_hit && (io_bus.host_cmd == 3'b001);
  assign w_wdata = io_bus.host_datain;

  always_comb begin
    w_sel   = '0;
    w_busy  = '0;
    w_ack   = '0;
    w_abort = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      w_sel[c]   = w_hit && (w_ch == 3'(c));
      w_busy[c]  = (r_state[c] == StBusy);
      w_ack[c]   = r_req && io_bus.xfer_ack && (r_gnt == 3'(c));
      w_abort[c] = w_wr && w_hit && (w_ch == 3'(c)) && (w_reg == 3'd4) && w_wdata[6]
                   && (r_state[c] == StBusy);
      w_step[c]  = LEN_W'(1) << r_size[c];
    end
  end

  // Status W1C is evaluated before hardware sets so that a same-cycle set wins.
  always_ff @(posedge clk0 or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < NUM_CH; c++) begin
        r_src[c]   <= '0;
        r_dst[c]   <= '0;
        r_len[c]   <= '0;
        r_size[c]  <= '0;
        r_state[c] <= StIdle;
      end
      r_sinc <= '0;
      r_dinc <= '0;
      r_ien  <= '0;
      r_done <= '0;
      r_err  <= '0;
      r_abt  <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (w_wr && w_sel[c] && (w_reg == 3'd0)) begin
          if (w_wdata[0]) r_done[c] <= 1'b0;
          if (w_wdata[2]) r_err[c]  <= 1'b0;
          if (w_wdata[3]) r_abt[c]  <= 1'b0;
        end
        if (w_wr && w_sel[c] && (r_state[c] != StBusy)) begin
          case (w_reg)
            3'd1: r_src[c] <= w_wdata;
            3'd2: r_dst[c] <= w_wdata;
            3'd3: r_len[c] <= w_wdata[LEN_W-1:0];
            3'd4: begin
              r_size[c] <= w_wdata[1:0];
              r_sinc[c] <= w_wdata[2];
              r_dinc[c] <= w_wdata[3];
              r_ien[c]  <= w_wdata[4];
            end
            default: ;
          endcase
        end
        case (r_state[c])
          StIdle: begin
            if (w_wr && w_sel[c] && (w_reg == 3'd4) && w_wdata[5]) begin
              if ((r_len[c] == '0) || (w_wdata[1:0] == 2'd3)) begin
                r_state[c] <= StDone;
                r_done[c]  <= 1'b1;
                r_err[c]   <= 1'b1;
              end else begin
                r_state[c] <= StBusy;
              end
            end
          end
          StBusy: begin
            if (w_abort[c]) begin
              r_state[c] <= StIdle;
              r_abt[c]   <= 1'b1;
            end else if (w_ack[c]) begin
              if (r_sinc[c]) r_src[c] <= r_src[c] + DATA_W'(w_step[c]);
              if (r_dinc[c]) r_dst[c] <= r_dst[c] + DATA_W'(w_step[c]);
              if (w_step[c] >= r_len[c]) begin
                r_len[c]   <= '0;
                r_state[c] <= StDone;
                r_done[c]  <= 1'b1;
              end else begin
                r_len[c] <= r_len[c] - w_step[c];
              end
            end
          end
          StDone: begin
            if (w_wr && w_sel[c] && (w_reg == 3'd0) && !(r_done[c] && !w_wdata[0])
                && !(r_err[c] && !w_wdata[2])) begin
              r_state[c] <= StIdle;
            end
          end
          default: r_state[c] <= StIdle;
        endcase
      end
    end
  end

  always_comb begin
    w_found  = 1'b0;
    w_next   = '0;
    w_gabort = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (!w_found && w_busy[c] && (c == (int'(r_ptr) + i) % NUM_CH)) begin
          w_found = 1'b1;
          w_next  = 3'(c);
        end
      end
    end
    for (int c = 0; c < NUM_CH; c++) begin
      if ((r_gnt == 3'(c)) && w_abort[c]) w_gabort = 1'b1;
    end
  end

  always_ff @(posedge clk0 or posedge reset) begin
    if (reset) begin
      r_req <= 1'b0;
      r_gnt <= '0;
      r_ptr <= '0;
    end else if (r_req) begin
      if (io_bus.xfer_ack || w_gabort) r_req <= 1'b0;
    end else if (w_found) begin
      r_req <= 1'b1;
      r_gnt <= w_next;
      r_ptr <= 3'((int'(w_next) + 1) % NUM_CH);
    end
  end

  always_comb begin
    w_rdata = '0;
    w_xsrc  = '0;
    w_xdst  = '0;
    w_xsize = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (w_ch == 3'(c)) begin
        case (w_reg)
          3'd0: w_rdata = DATA_W'({r_abt[c], r_err[c], w_busy[c], r_done[c]});
          3'd1: w_rdata = r_src[c];
          3'd2: w_rdata = r_dst[c];
          3'd3: w_rdata = DATA_W'(r_len[c]);
          3'd4: w_rdata = DATA_W'({r_ien[c], r_dinc[c], r_sinc[c], r_size[c]});
          default: w_rdata = '0;
        endcase
      end
      if (r_req && (r_gnt == 3'(c))) begin
        w_xsrc  = r_src[c];
        w_xdst  = r_dst[c];
        w_xsize = r_size[c];
      end
    end
  end

  always_ff @(posedge clk0 or posedge reset) begin
    if (reset) begin
      r_rdata    <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= w_rd;
      if (w_rd) r_rdata <= w_rdata;
    end
  end

  assign io_bus.host_dataout  = r_rdata;
  assign io_bus.host_rd_valid = r_rd_valid;
  assign io_bus.xfer_req      = r_req;
  assign io_bus.xfer_ch       = r_gnt;
  assign io_bus.xfer_src      = w_xsrc;
  assign io_bus.xfer_dst      = w_xdst;
  assign io_bus.xfer_size     = w_xsize;
  assign io_bus.irq           = r_ien & (r_done | r_err | r_abt);

endmodule

// File: tb/tb_dma_chan_reg_file.sv
// Directed bench for dma_chan_reg_file: register access, transfers, arbitration, abort, reset.
module tb_dma_chan_reg_file;

  localparam logic [23:0] Base = 24'h080000;

  logic clk0  = 1'b0;
  logic reset = 1'b1;
  int   n_total = 0;
  int   n_bad   = 0;

  dma_chan_reg_file_if bus_if ();

  dma_chan_reg_file dut (
    .clk0   (clk0),
    .reset  (reset),
    .io_bus (bus_if)
  );

  always #5 clk0 = ~clk0;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] ra(input int ch, input int off);
    return Base + 24'(8 * ch + off);
  endfunction

  task automatic host_wr(input int ch, input int off, input logic [31:0] d);
    @(negedge clk0);
    bus_if.host_cmd    = 3'b010;
    bus_if.host_addr   = ra(ch, off);
    bus_if.host_datain = d;
    @(negedge clk0);
    bus_if.host_cmd    = 3'b000;
  endtask

  task automatic host_rd(input logic [23:0] a, output logic [31:0] d, output logic v);
    @(negedge clk0);
    bus_if.host_cmd  = 3'b001;
    bus_if.host_addr = a;
    @(negedge clk0);
    bus_if.host_cmd  = 3'b000;
    d = bus_if.host_dataout;
    v = bus_if.host_rd_valid;
  endtask

  task automatic rd_check(input string tag, input int ch, input int off, input logic [31:0] exp);
    logic [31:0] d;
    logic        v;
    host_rd(ra(ch, off), d, v);
    check({tag, "_vld"}, 32'(v), 32'd1);
    check(tag, d, exp);
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    while (!bus_if.xfer_req && n < 20) begin
      @(negedge clk0);
      n++;
    end
    if (!bus_if.xfer_req) check({tag, "_req_timeout"}, 32'd0, 32'd1);
  endtask

  // Waits for a request, samples the beat attributes, then acks for one cycle.
  task automatic ack_beat(input string tag, output int ch, output logic [31:0] src,
                          output logic [1:0] sz);
    ch  = -1;
    src = '0;
    sz  = '0;
    wait_req(tag);
    if (bus_if.xfer_req) begin
      ch  = int'(bus_if.xfer_ch);
      src = bus_if.xfer_src;
      sz  = bus_if.xfer_size;
      bus_if.xfer_ack = 1'b1;
      @(negedge clk0);
      bus_if.xfer_ack = 1'b0;
    end
  endtask

  initial begin
    logic [31:0] d;
    logic        v;
    int          ch;
    logic [31:0] src;
    logic [1:0]  sz;
    logic        seen;

    bus_if.host_cmd    = 3'b000;
    bus_if.host_addr   = '0;
    bus_if.host_datain = '0;
    bus_if.xfer_ack    = 1'b0;
    repeat (2) @(negedge clk0);
    reset = 1'b0;

    check("rst_req", 32'(bus_if.xfer_req), 32'd0);
    check("rst_irq", 32'(bus_if.irq), 32'd0);
    check("rst_rdv", 32'(bus_if.host_rd_valid), 32'd0);
    check("rst_dout", bus_if.host_dataout, 32'd0);
    rd_check("rst_len0", 0, 3, 32'd0);
    host_wr(0, 5, 32'hFFFF);
    rd_check("off5", 0, 5, 32'd0);
    host_rd(ra(4, 0), d, v);
    check("oob_vld", 32'(v), 32'd0);

    // Ch0 word transfer, both addresses incrementing, interrupt enabled
    host_wr(0, 1, 32'h100);
    host_wr(0, 2, 32'h200);
    host_wr(0, 3, 32'd8);
    host_wr(0, 4, 32'h3E);
    rd_check("c0_busy", 0, 0, 32'h2);
    rd_check("c0_ctrl", 0, 4, 32'h1E);
    ack_beat("c0_b0", ch, src, sz);
    check("c0_b0_ch", 32'(ch), 32'd0);
    check("c0_b0_src", src, 32'h100);
    check("c0_b0_sz", 32'(sz), 32'd2);
    rd_check("c0_len4", 0, 3, 32'd4);
    ack_beat("c0_b1", ch, src, sz);
    check("c0_b1_src", src, 32'h104);
    rd_check("c0_src", 0, 1, 32'h108);
    rd_check("c0_dst", 0, 2, 32'h208);
    rd_check("c0_len0", 0, 3, 32'd0);
    rd_check("c0_done", 0, 0, 32'h1);
    check("c0_irq", 32'(bus_if.irq), 32'h1);
    host_wr(0, 0, 32'h1);
    rd_check("c0_clr", 0, 0, 32'h0);
    check("c0_irq_clr", 32'(bus_if.irq), 32'h0);

    // Ch1 half-word steps over an odd length
    host_wr(1, 3, 32'd3);
    host_wr(1, 4, 32'h21);
    ack_beat("c1_b0", ch, src, sz);
    check("c1_b0_ch", 32'(ch), 32'd1);
    check("c1_b0_sz", 32'(sz), 32'd1);
    rd_check("c1_len1", 1, 3, 32'd1);
    rd_check("c1_busy", 1, 0, 32'h2);
    ack_beat("c1_b1", ch, src, sz);
    rd_check("c1_len0", 1, 3, 32'd0);
    rd_check("c1_done", 1, 0, 32'h1);
    check("c1_noirq", 32'(bus_if.irq), 32'h0);
    host_wr(1, 0, 32'h1);

    // Ch2 go with zero length is an error, never requests
    host_wr(2, 3, 32'd0);
    host_wr(2, 4, 32'h20);
    seen = 1'b0;
    repeat (3) begin
      if (bus_if.xfer_req) seen = 1'b1;
      @(negedge clk0);
    end
    check("c2_noreq", 32'(seen), 32'd0);
    rd_check("c2_err", 2, 0, 32'h5);
    host_wr(2, 0, 32'h5);
    rd_check("c2_clr", 2, 0, 32'h0);
    host_wr(2, 4, 32'h20);
    rd_check("c2_idle", 2, 0, 32'h5);
    host_wr(2, 0, 32'h5);

    // Ch0 and ch3 competing, byte beats
    host_wr(0, 3, 32'd8);
    host_wr(3, 3, 32'd8);
    host_wr(0, 4, 32'h20);
    host_wr(3, 4, 32'h20);
    for (int k = 0; k < 4; k++) begin
      ack_beat("rr", ch, src, sz);
      check($sformatf("rr_ch%0d", k), 32'(ch), (k % 2 == 1) ? 32'd3 : 32'd0);
    end
    host_wr(0, 4, 32'h40);
    host_wr(3, 4, 32'h40);
    check("rr_req_off", 32'(bus_if.xfer_req), 32'd0);
    rd_check("rr_c0_abt", 0, 0, 32'h8);
    rd_check("rr_c3_len", 3, 3, 32'd6);
    host_wr(0, 0, 32'h8);
    host_wr(3, 0, 32'h8);

    // Ch1 abort and ack in the same cycle: abort wins
    host_wr(1, 3, 32'd6);
    host_wr(1, 4, 32'h21);
    wait_req("c1_abt");
    bus_if.host_cmd    = 3'b010;
    bus_if.host_addr   = ra(1, 4);
    bus_if.host_datain = 32'h40;
    bus_if.xfer_ack    = 1'b1;
    @(negedge clk0);
    bus_if.host_cmd = 3'b000;
    bus_if.xfer_ack = 1'b0;
    check("c1_abt_req", 32'(bus_if.xfer_req), 32'd0);
    rd_check("c1_abt_len", 1, 3, 32'd6);
    rd_check("c1_abt_st", 1, 0, 32'h8);
    host_wr(1, 0, 32'h8);
    rd_check("c1_abt_clr", 1, 0, 32'h0);

    // Reset in the middle of a transfer
    host_wr(0, 3, 32'd0);
    host_wr(0, 4, 32'h30);
    host_wr(2, 1, 32'h55);
    host_wr(2, 3, 32'd8);
    host_wr(2, 4, 32'h2C);
    rd_check("pre_rst_st", 0, 0, 32'h5);
    wait_req("pre_rst");
    check("pre_rst_irq", 32'(bus_if.irq), 32'h1);
    #2;
    reset = 1'b1;
    #1;
    check("arst_req", 32'(bus_if.xfer_req), 32'd0);
    check("arst_irq", 32'(bus_if.irq), 32'd0);
    check("arst_dout", bus_if.host_dataout, 32'd0);
    check("arst_src", bus_if.xfer_src, 32'd0);
    @(negedge clk0);
    reset = 1'b0;
    rd_check("post_rst", 1, 0, 32'd0);
    @(negedge clk0);
    check("post_rst_rdv", 32'(bus_if.host_rd_valid), 32'd0);
    rd_check("post_rst_len", 2, 3, 32'd0);
    check("post_rst_req", 32'(bus_if.xfer_req), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
